// File: rtl/result_collect_wb.sv
// ----------------------------------------------------------------------------
// result_collect_wb
//
// Return path of the operand demux. Every dispatched operation records its
// opcode and destination register in an in-order completion queue. Results
// are taken only from the functional unit that owns the head entry. Each
// accepted result is parked in a single output register until the register
// file takes it. A drain and a new accept may happen in the same cycle, so
// sustained throughput is one result per cycle.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   issue_valid/ready dispatch handshake (ready = queue not full)
//   issue_opcode/rd   opcode (0..6 legal) and destination of the dispatched op
//   illegal_op        one-cycle pulse: handshake attempted with opcode > 6
//   unit_valid/ready  per-unit result handshake, bit k = opcode k
//                     (add, sub, mul, div, and, or, xor)
//   *_res             per-unit result values
//   wb_valid/ready    writeback handshake toward the register file
//   wb_data/wb_rd     writeback value and destination
//   stray_result      one-cycle pulse: a unit other than the head's unit was valid
// ----------------------------------------------------------------------------
module result_collect_wb #(
    parameter int N        = 16,
    parameter int SEL_LINE = 4,
    parameter int RD_W     = 4,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [SEL_LINE-1:0] issue_opcode,
    input  logic [RD_W-1:0]     issue_rd,
    output logic                illegal_op,
    input  logic [6:0]          unit_valid,
    output logic [6:0]          unit_ready,
    input  logic [N-1:0]        add_res,
    input  logic [N-1:0]        sub_res,
    input  logic [N-1:0]        mul_res,
    input  logic [N-1:0]        div_res,
    input  logic [N-1:0]        and_res,
    input  logic [N-1:0]        or_res,
    input  logic [N-1:0]        xor_res,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [N-1:0]        wb_data,
    output logic [RD_W-1:0]     wb_rd,
    output logic                stray_result
);

    localparam int PTR_W     = $clog2(DEPTH);
    localparam int NUM_UNITS = 7;

    localparam logic [SEL_LINE-1:0] OP_ADD = SEL_LINE'(0);
    localparam logic [SEL_LINE-1:0] OP_SUB = SEL_LINE'(1);
    localparam logic [SEL_LINE-1:0] OP_MUL = SEL_LINE'(2);
    localparam logic [SEL_LINE-1:0] OP_DIV = SEL_LINE'(3);
    localparam logic [SEL_LINE-1:0] OP_AND = SEL_LINE'(4);
    localparam logic [SEL_LINE-1:0] OP_OR  = SEL_LINE'(5);
    localparam logic [SEL_LINE-1:0] OP_XOR = SEL_LINE'(6);

    typedef struct packed {
        logic [SEL_LINE-1:0] opcode;
        logic [RD_W-1:0]     rd;
    } entry_t;

    entry_t           queue_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    entry_t           head;
    logic             not_empty;
    logic             legal;
    logic             push;
    logic             accept;
    logic             slot_free;
    logic             stray_next;
    logic [6:0]       head_onehot;
    logic [N-1:0]     head_result;

    assign head        = queue_mem[rd_ptr];
    assign not_empty   = (count != '0);
    assign issue_ready = (count < (PTR_W+1)'(DEPTH));
    assign legal       = (issue_opcode <= OP_XOR);
    assign push        = issue_valid & issue_ready & legal;
    assign slot_free   = ~wb_valid | wb_ready;

    // Only the head's unit is eligible; an empty queue owns no unit.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        head_onehot = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (not_empty && head.opcode == SEL_LINE'(k)) begin
                head_onehot[k] = 1'b1;
            end
        end
    end

    assign unit_ready = slot_free ? head_onehot : '0;
    assign accept     = |(unit_valid & unit_ready);
    // The head's own unit waiting on a full slot is backpressure, not a stray.
    assign stray_next = |(unit_valid & ~head_onehot);

    always_comb begin
        head_result = '0;
        case (head.opcode)
            OP_ADD:  head_result = add_res;
            OP_SUB:  head_result = sub_res;
            OP_MUL:  head_result = mul_res;
            OP_DIV:  head_result = div_res;
            OP_AND:  head_result = and_res;
            OP_OR:   head_result = or_res;
            OP_XOR:  head_result = xor_res;
            default: head_result = '0;
        endcase
    end

    // NOTE: queue storage carries no reset; an entry is only read once count
    // covers it, so clearing the pointers and count is enough.
    always_ff @(posedge clk) begin
        if (push) begin
            queue_mem[wr_ptr] <= '{opcode: issue_opcode, rd: issue_rd};
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            illegal_op   <= 1'b0;
            stray_result <= 1'b0;
        end else begin
            illegal_op   <= issue_valid & issue_ready & ~legal;
            stray_result <= stray_next;

            // Pointers wrap naturally because DEPTH is a power of two.
            if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
            if (accept) rd_ptr <= rd_ptr + PTR_W'(1);

            case ({push, accept})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase

            // An accept overrides a drain in the same cycle: back-to-back.
            if (accept) begin
                wb_valid <= 1'b1;
                wb_data  <= head_result;
                wb_rd    <= head.rd;
            end else if (wb_ready) begin
                wb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_result_collect_wb.sv
module tb_result_collect_wb;

    localparam int N        = 16;
    localparam int SEL_LINE = 4;
    localparam int RD_W     = 4;
    localparam int DEPTH    = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                issue_valid;
    logic                issue_ready;
    logic [SEL_LINE-1:0] issue_opcode;
    logic [RD_W-1:0]     issue_rd;
    logic                illegal_op;
    logic [6:0]          unit_valid;
    logic [6:0]          unit_ready;
    logic [N-1:0]        res [7];
    logic                wb_valid;
    logic                wb_ready;
    logic [N-1:0]        wb_data;
    logic [RD_W-1:0]     wb_rd;
    logic                stray_result;

    always #5 clk = ~clk;

    result_collect_wb #(.N(N), .SEL_LINE(SEL_LINE), .RD_W(RD_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_opcode(issue_opcode), .issue_rd(issue_rd),
        .illegal_op(illegal_op),
        .unit_valid(unit_valid), .unit_ready(unit_ready),
        .add_res(res[0]), .sub_res(res[1]), .mul_res(res[2]), .div_res(res[3]),
        .and_res(res[4]), .or_res(res[5]), .xor_res(res[6]),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_rd(wb_rd),
        .stray_result(stray_result)
    );

    // Reference model: the list of outstanding operations in issue order, each
    // carrying the result its unit will eventually deliver, plus the single
    // output register seen by the register file.
    typedef struct {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [15:0] data;
    } op_t;

    op_t         pending[$];
    logic [15:0] exp_data_q[$];
    logic [3:0]  exp_rd_q[$];
    bit          hold [7];

    logic        m_wb_valid;
    logic [15:0] m_wb_data;
    logic [3:0]  m_wb_rd;
    bit          m_loaded;
    logic        m_illegal;
    logic        m_stray;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Index in 'pending' of the oldest operation owned by unit k, or -1.
    function automatic int first_of_unit(input int k);
        for (int i = 0; i < pending.size(); i++) begin
            if (int'(pending[i].op) == k) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        pending.delete();
        exp_data_q.delete();
        exp_rd_q.delete();
        for (int k = 0; k < 7; k++) hold[k] = 0;
        m_wb_valid = 1'b0;
        m_wb_data  = '0;
        m_wb_rd    = '0;
        m_loaded   = 0;
        m_illegal  = 1'b0;
        m_stray    = 1'b0;
    endtask

    // One clock: check registered outputs, drive fresh inputs, check the
    // combinational handshakes, then advance the model across the next edge.
    task automatic cycle(input int p_issue, input int p_illegal, input int p_wb,
                         input int p_unit, input int p_rst);
        logic [6:0] uv;
        logic [6:0] head_oh;
        logic [6:0] exp_ur;
        bit         do_rst;
        bit         full;
        bit         accept;
        int         idx;
        op_t        head;

        @(negedge clk);
        check("wb_valid", wb_valid, m_wb_valid);
        if (m_wb_valid || !m_loaded) begin
            check("wb_data", wb_data, m_wb_data);
            check("wb_rd", wb_rd, m_wb_rd);
        end
        check("illegal_op", illegal_op, m_illegal);
        check("stray_result", stray_result, m_stray);

        do_rst       = ($urandom_range(999) < p_rst);
        rst          = do_rst;
        issue_valid  = !do_rst && ($urandom_range(99) < p_issue);
        issue_opcode = ($urandom_range(99) < p_illegal) ? 4'($urandom_range(15, 7))
                                                         : 4'($urandom_range(6));
        issue_rd     = 4'($urandom);
        wb_ready     = !do_rst && ($urandom_range(99) < p_wb);
        uv = '0;
        for (int k = 0; k < 7; k++) begin
            res[k] = 16'($urandom);
            idx = first_of_unit(k);
            if (do_rst) begin
                uv[k] = 1'b0;
            end else if (idx >= 0 && (hold[k] || $urandom_range(99) < p_unit)) begin
                // A unit raises valid on its oldest result and holds it.
                hold[k] = 1;
                uv[k]   = 1'b1;
                res[k]  = pending[idx].data;
            end else if (idx < 0 && $urandom_range(99) < 3) begin
                uv[k] = 1'b1;  // spurious result from an idle unit
            end
        end
        unit_valid = uv;

        #1;
        head_oh = '0;
        if (pending.size() != 0) head_oh[pending[0].op] = 1'b1;
        exp_ur = (!m_wb_valid || wb_ready) ? head_oh : 7'd0;
        check("issue_ready", issue_ready, pending.size() < DEPTH);
        check("unit_ready", unit_ready, exp_ur);

        if (do_rst) begin
            model_reset();
            return;
        end

        full      = (pending.size() >= DEPTH);
        accept    = |(uv & exp_ur);
        m_stray   = |(uv & ~head_oh);
        m_illegal = issue_valid && !full && (issue_opcode > 4'd6);

        if (accept) begin
            head       = pending.pop_front();
            hold[head.op] = 0;
            m_wb_valid = 1'b1;
            m_wb_data  = head.data;
            m_wb_rd    = head.rd;
            m_loaded   = 1;
            exp_data_q.push_back(head.data);
            exp_rd_q.push_back(head.rd);
        end else if (wb_ready) begin
            m_wb_valid = 1'b0;
        end

        if (issue_valid && !full && issue_opcode <= 4'd6) begin
            pending.push_back('{op: issue_opcode, rd: issue_rd, data: 16'($urandom)});
        end
    endtask

    // Scoreboard monitor: every writeback handshake consumes the oldest
    // expected result.
    initial begin
        logic [15:0] ed;
        logic [3:0]  er;
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0 && wb_valid === 1'b1 && wb_ready === 1'b1) begin
                if (exp_data_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: got data %0h rd %0h expected no writeback",
                             wb_data, wb_rd);
                end else begin
                    ed = exp_data_q.pop_front();
                    er = exp_rd_q.pop_front();
                    check("sb_wb_data", wb_data, ed);
                    check("sb_wb_rd", wb_rd, er);
                end
            end
        end
    end

    initial begin
        rst          = 1'b1;
        issue_valid  = 1'b0;
        issue_opcode = '0;
        issue_rd     = '0;
        unit_valid   = '0;
        wb_ready     = 1'b0;
        for (int k = 0; k < 7; k++) res[k] = '0;
        model_reset();
        repeat (2) @(posedge clk);

        // Mixed traffic with occasional mid-operation resets.
        for (int i = 0; i < 400; i++) cycle(50, 10, 50, 50, 10);
        // Heavy backpressure: queue fills, results wait in the output slot.
        for (int i = 0; i < 300; i++) cycle(80, 5, 10, 60, 0);
        // Streaming: writeback always ready, units respond immediately.
        for (int i = 0; i < 300; i++) cycle(70, 5, 100, 100, 5);
        // Drain everything still outstanding.
        for (int i = 0; i < 60; i++) cycle(0, 0, 100, 100, 0);

        @(negedge clk);
        #3;
        check("drain_scoreboard_empty", exp_data_q.size(), 0);
        check("drain_wb_valid", wb_valid, 1'b0);
        check("drain_issue_ready", issue_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
